operand_loader: RTL and testbench

Bit-serial operand front end for the 4-bit logic/ALU datapath. It receives two WIDTH-bit operands over a single serial line and assembles them in shadow shift registers. It then presents them in parallel on a_out/b_out, which drive the A/B inputs of the bitwise AND stage and its sibling logic stages. A valid/ready handshake holds the operands stable until the downstream stage has consumed them.

---
 rtl/operand_loader.sv | 92 +++++++++
 tb/tb_operand_loader.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/operand_loader.sv
// rtl/operand_loader.sv - bit-serial loader assembling two WIDTH-bit operands for the logic datapath
module operand_loader #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sin,
  input  logic             sin_valid,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             err
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOAD_A = 2'd1;
  localparam logic [1:0] LOAD_B = 2'd2;
  localparam logic [1:0] HOLD   = 2'd3;

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shift_a;
  logic [WIDTH-1:0] shift_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      shift_a <= '0;
      shift_b <= '0;
      a_out   <= '0;
      b_out   <= '0;
      err     <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= LOAD_A;
            cnt     <= '0;
            shift_a <= '0;
            shift_b <= '0;
          end
        end
        LOAD_A, LOAD_B: begin
          // A restart wins over any bit presented in the same cycle.
          if (start) begin
            state   <= LOAD_A;
            cnt     <= '0;
            shift_a <= '0;
            shift_b <= '0;
            err     <= 1'b1;
          end else if (sin_valid) begin
            if (state == LOAD_A) begin
              shift_a <= {shift_a[WIDTH-2:0], sin};
            end else begin
              shift_b <= {shift_b[WIDTH-2:0], sin};
            end
            if (cnt == LAST_BIT) begin
              cnt <= '0;
              if (state == LOAD_A) begin
                state <= LOAD_B;
              end else begin
                a_out <= shift_a;
                b_out <= {shift_b[WIDTH-2:0], sin};
                state <= HOLD;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign out_valid = (state == HOLD);

endmodule

// File: tb/tb_operand_loader.sv
// tb/tb_operand_loader.sv - randomized and directed bench for operand_loader against a frame-level model
module tb_operand_loader;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sin;
  logic         sin_valid;
  logic [W-1:0] a_out;
  logic [W-1:0] b_out;
  logic         out_valid;
  logic         out_ready;
  logic         busy;
  logic         err;

  operand_loader #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sin       (sin),
    .sin_valid (sin_valid),
    .a_out     (a_out),
    .b_out     (b_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Frame-level model: a frame is the list of bits received since start.
  logic         m_in_frame = 1'b0;
  logic         m_holding  = 1'b0;
  logic [W-1:0] m_a        = '0;
  logic [W-1:0] m_b        = '0;
  logic         m_err      = 1'b0;
  logic         bits[$];
  int           steps_since_start = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_update(input logic st, input logic b, input logic bv,
                              input logic rdy, input logic r);
    m_err = 1'b0;
    if (r) begin
      m_in_frame = 1'b0;
      m_holding  = 1'b0;
      m_a        = '0;
      m_b        = '0;
      bits.delete();
    end else if (m_holding) begin
      if (rdy) m_holding = 1'b0;
    end else if (m_in_frame) begin
      if (st) begin
        bits.delete();
        m_err = 1'b1;
      end else if (bv) begin
        bits.push_back(b);
        if (bits.size() == 2 * W) begin
          m_a = '0;
          m_b = '0;
          for (int i = 0; i < W; i++) begin
            m_a = (m_a << 1) | W'(bits[i]);
            m_b = (m_b << 1) | W'(bits[W + i]);
          end
          m_holding  = 1'b1;
          m_in_frame = 1'b0;
        end
      end
    end else if (st) begin
      m_in_frame = 1'b1;
      bits.delete();
    end
  endtask

  task automatic step(input logic st, input logic b, input logic bv,
                      input logic rdy, input logic r);
    start     = st;
    sin       = b;
    sin_valid = bv;
    out_ready = rdy;
    rst       = r;
    model_update(st, b, bv, rdy, r);
    @(posedge clk);
    #1;
    steps_since_start++;
    check("a_out", 32'(a_out), 32'(m_a));
    check("b_out", 32'(b_out), 32'(m_b));
    check("out_valid", 32'(out_valid), 32'(m_holding));
    check("busy", 32'(busy), 32'(m_in_frame | m_holding));
    check("err", 32'(err), 32'(m_err));
  endtask

  // Sends a frame MSB first; optional start and a stall cycle before each bit.
  task automatic send_frame(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic do_start, input logic stall, input logic rdy);
    logic [2*W-1:0] f;
    f = {a, b};
    steps_since_start = 0;
    if (do_start) step(1'b1, 1'b0, 1'b1, rdy, 1'b0);
    for (int i = 2 * W - 1; i >= 0; i--) begin
      if (stall) step(1'b0, 1'($urandom), 1'b0, rdy, 1'b0);
      step(1'b0, f[i], 1'b1, 1'b0, 1'b0);
    end
  endtask

  initial begin
    start = 0; sin = 0; sin_valid = 0; out_ready = 0; rst = 1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("reset_a", 32'(a_out), 32'h0);
    check("reset_valid", 32'(out_valid), 32'h0);

    // Basic load and latency
    send_frame(4'b0101, 4'b1001, 1'b1, 1'b0, 1'b1);
    check("basic_latency", 32'(steps_since_start), 32'(1 + 2 * W));
    check("basic_a", 32'(a_out), 32'h5);
    check("basic_b", 32'(b_out), 32'h9);
    check("basic_valid", 32'(out_valid), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("basic_drop", 32'(out_valid), 32'h0);
    check("basic_idle", 32'(busy), 32'h0);

    // Hold-over: previous pair stays visible mid-frame
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("holdover_a", 32'(a_out), 32'h5);
    check("holdover_b", 32'(b_out), 32'h9);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Backpressure with ignored start/sin_valid in HOLD
    send_frame(4'b0110, 4'b1101, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'(i & 1), 1'b1, 1'b1, 1'b0, 1'b0);
    check("bp_a", 32'(a_out), 32'h6);
    check("bp_b", 32'(b_out), 32'hd);
    check("bp_valid", 32'(out_valid), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("bp_release", 32'(busy), 32'h0);

    // Stalled frame takes 2*W extra cycles
    send_frame(4'b1000, 4'b1000, 1'b1, 1'b1, 1'b0);
    check("stall_latency", 32'(steps_since_start), 32'(1 + 4 * W));
    check("stall_a", 32'(a_out), 32'h8);
    check("stall_b", 32'(b_out), 32'h8);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Abort mid-A then a fresh frame without another start
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("abort_err", 32'(err), 32'h1);
    check("abort_busy", 32'(busy), 32'h1);
    send_frame(4'b0011, 4'b1100, 1'b0, 1'b0, 1'b0);
    check("abort_a", 32'(a_out), 32'h3);
    check("abort_b", 32'(b_out), 32'hc);
    check("abort_err_gone", 32'(err), 32'h0);

    // Reset during HOLD, then reset during LOAD_B
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("rst_hold_a", 32'(a_out), 32'h0);
    check("rst_hold_busy", 32'(busy), 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < W + 2; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    check("rst_loadb_busy", 32'(busy), 32'h0);
    send_frame(4'b0000, 4'b1111, 1'b1, 1'b0, 1'b0);
    check("post_rst_a", 32'(a_out), 32'h0);
    check("post_rst_b", 32'(b_out), 32'hf);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Random traffic, every cycle checked against the model
    for (int i = 0; i < 2000; i++) begin
      step(1'($urandom_range(0, 19) == 0), 1'($urandom), 1'($urandom_range(0, 9) < 7),
           1'($urandom), 1'($urandom_range(0, 99) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
